frame_reader_mc: RTL and testbench



---
 rtl/frame_reader_mc.sv | 184 ++++++++++++++++++
 tb/tb_frame_reader_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader_mc.sv
// frame_reader_mc: walks up to CHANNELS sample buffers after a frame-complete
// pulse and streams their contents (optionally prefixed by a per-channel
// header word) over a valid/ready interface. Mask and lengths are snapshotted
// at start so the upstream writer can move on to the next frame immediately.
module frame_reader_mc #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int HDR_EN   = 1,
    localparam int RW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [CHANNELS-1:0]        i_chan_mask,
    input  logic [CHANNELS*ADDR_W-1:0] i_data_len,
    output logic [RW-1:0]              o_rd_chn,
    output logic [ADDR_W-1:0]          o_rd_addr,
    input  logic [DATA_W-1:0]          i_rd_data,
    output logic [DATA_W-1:0]          o_out_data,
    output logic                       o_out_vld,
    input  logic                       i_out_rdy,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overrun,
    output logic [15:0]                o_word_count
);

    // channel counter must be able to hold CHANNELS itself (the end marker)
    localparam int CW = $clog2(CHANNELS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_HDR, S_RD, S_CAP, S_OUT, S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    chn_q, chn_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [CHANNELS-1:0]              mask_q, mask_d;
    logic [CHANNELS-1:0][ADDR_W-1:0]  len_q, len_d;
    logic [RW-1:0]                    rd_chn_q, rd_chn_d;
    logic [ADDR_W-1:0]                rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]                out_q, out_d;
    logic                             ovr_q, ovr_d;
    logic [15:0]                      cnt_q, cnt_d;

    logic [RW-1:0]                    ci;
    logic [ADDR_W-1:0]                len_cur;
    logic                             mask_cur;
    logic                             xfer;
    logic [31:0]                      hdr;

    assign o_rd_chn     = rd_chn_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_out_data   = out_q;
    assign o_out_vld    = (state_q == S_HDR) || (state_q == S_OUT);
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done       = (state_q == S_DONE);
    assign o_overrun    = ovr_q;
    assign o_word_count = cnt_q;

    // next-state and datapath updates; all registers default to hold
    always_comb begin
        state_d   = state_q;
        chn_d     = chn_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        len_d     = len_q;
        rd_chn_d  = rd_chn_q;
        rd_addr_d = rd_addr_q;
        out_d     = out_q;
        ovr_d     = ovr_q;
        cnt_d     = cnt_q;

        ci       = chn_q[RW-1:0];
        len_cur  = len_q[ci];
        mask_cur = mask_q[ci];
        xfer     = o_out_vld & i_out_rdy;
        hdr      = {8'hA5, 8'(chn_q), 16'(len_cur)};

        // a start that is not accepted from IDLE (including the DONE cycle)
        if (i_start && state_q != S_IDLE)
            ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mask_d  = i_chan_mask;
                    len_d   = i_data_len;
                    chn_d   = '0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (chn_q == CW'(CHANNELS)) begin
                    state_d = S_DONE;
                end else if (!mask_cur) begin
                    chn_d = chn_q + CW'(1);
                end else if (HDR_EN != 0) begin
                    out_d   = DATA_W'(hdr);
                    state_d = S_HDR;
                end else if (len_cur == '0) begin
                    chn_d = chn_q + CW'(1);
                end else begin
                    state_d = S_RD;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (len_cur == '0) begin
                        chn_d   = chn_q + CW'(1);
                        state_d = S_SEL;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                out_d   = i_rd_data;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (xfer) begin
                    if (addr_q == len_cur - ADDR_W'(1)) begin
                        addr_d  = '0;
                        chn_d   = chn_q + CW'(1);
                        state_d = S_SEL;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer)
            cnt_d = cnt_q + 16'd1;

        // read port only moves when a read is issued, so it never shows
        // channels that are merely being skipped
        if (state_d == S_RD) begin
            rd_chn_d  = chn_d[RW-1:0];
            rd_addr_d = addr_d;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chn_q     <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            len_q     <= '0;
            rd_chn_q  <= '0;
            rd_addr_q <= '0;
            out_q     <= '0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            chn_q     <= chn_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            len_q     <= len_d;
            rd_chn_q  <= rd_chn_d;
            rd_addr_q <= rd_addr_d;
            out_q     <= out_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_frame_reader_mc.sv
// tb_frame_reader_mc: directed bench with two readers (header on / header off)
// sharing the same stimulus; each has a RAM model returning D000_{chn}{addr}.
module tb_frame_reader_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mask = '0;
    logic [31:0] lens = '0;
    logic        rdy_fix = 1'b1;
    logic        rnd_rdy = 1'b0;
    logic        rnd_bit = 1'b0;
    logic        rdy;

    logic [1:0]  rd_chn_h, rd_chn_n;
    logic [7:0]  rd_addr_h, rd_addr_n;
    logic [31:0] rd_data_h = '0, rd_data_n = '0;
    logic [31:0] data_h, data_n;
    logic        vld_h, vld_n, busy_h, busy_n, done_h, done_n, ovr_h, ovr_n;
    logic [15:0] cnt_h, cnt_n;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] q_h[$];
    logic [31:0] q_n[$];
    int          done_ch = 0, done_cn = 0, busy_cyc = 0, bad_chn = 0, stab_err = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_d = '0;
    logic [1:0]  prev_chn_n = '0;

    always #5 clk = ~clk;

    assign rdy = rnd_rdy ? rnd_bit : rdy_fix;

    frame_reader_mc #(.CHANNELS(4), .ADDR_W(8), .DATA_W(32), .HDR_EN(1)) u_h (
        .clk(clk), .rst(rst), .i_start(start), .i_chan_mask(mask), .i_data_len(lens),
        .o_rd_chn(rd_chn_h), .o_rd_addr(rd_addr_h), .i_rd_data(rd_data_h),
        .o_out_data(data_h), .o_out_vld(vld_h), .i_out_rdy(rdy), .o_busy(busy_h),
        .o_done(done_h), .o_overrun(ovr_h), .o_word_count(cnt_h));

    frame_reader_mc #(.CHANNELS(4), .ADDR_W(8), .DATA_W(32), .HDR_EN(0)) u_n (
        .clk(clk), .rst(rst), .i_start(start), .i_chan_mask(mask), .i_data_len(lens),
        .o_rd_chn(rd_chn_n), .o_rd_addr(rd_addr_n), .i_rd_data(rd_data_n),
        .o_out_data(data_n), .o_out_vld(vld_n), .i_out_rdy(rdy), .o_busy(busy_n),
        .o_done(done_n), .o_overrun(ovr_n), .o_word_count(cnt_n));

    // 1-cycle-latency buffer models
    always @(posedge clk) begin
        rd_data_h <= {16'hD000, 6'd0, rd_chn_h, rd_addr_h};
        rd_data_n <= {16'hD000, 6'd0, rd_chn_n, rd_addr_n};
    end

    always @(posedge clk) begin
        #1 rnd_bit <= 1'($urandom_range(0, 1));
    end

    // stream monitor: collects transfers, counts events, checks hold rules
    always @(negedge clk) begin
        if (!rst) begin
            if (vld_h && rdy) q_h.push_back(data_h);
            if (vld_n && rdy) q_n.push_back(data_n);
            if (done_h) done_ch <= done_ch + 1;
            if (done_n) done_cn <= done_cn + 1;
            if (busy_h) busy_cyc <= busy_cyc + 1;
            if (hold && (!vld_h || data_h != hold_d)) stab_err <= stab_err + 1;
            if (rd_chn_n != prev_chn_n && (rd_chn_n == 2'd1 || rd_chn_n == 2'd3))
                bad_chn <= bad_chn + 1;
            prev_chn_n <= rd_chn_n;
            hold       <= vld_h && !rdy;
            hold_d     <= data_h;
        end else begin
            hold <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic check_seq(input string tag, input bit hdr, input int base,
                             input logic [31:0] exp[$]);
        int got;
        got = (hdr ? q_h.size() : q_n.size()) - base;
        check({tag, "_len"}, got, exp.size());
        for (int i = 0; i < exp.size() && i < got; i++)
            check($sformatf("%s_w%0d", tag, i), hdr ? q_h[base+i] : q_n[base+i], exp[i]);
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [31:0] l);
        @(posedge clk); #1;
        start = 1'b1; mask = m; lens = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // waits for both readers to finish; an expired budget is a failed check
    task automatic wait_done(input string tag, input int d0h, input int d0n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_ch != d0h && done_cn != d0n) begin ok = 1'b1; break; end
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [31:0] exp1_h[$] = '{32'hA5000002, 32'hD0000000, 32'hD0000001, 32'hA5010001,
                              32'hD0000100, 32'hA5020003, 32'hD0000200, 32'hD0000201,
                              32'hD0000202, 32'hA5030000};
    logic [31:0] exp1_n[$] = '{32'hD0000000, 32'hD0000001, 32'hD0000100,
                              32'hD0000200, 32'hD0000201, 32'hD0000202};
    logic [31:0] exp2_n[$] = '{32'hD0000000, 32'hD0000001, 32'hD0000002,
                              32'hD0000200, 32'hD0000201, 32'hD0000202};
    localparam logic [31:0] LENS1 = {8'd0, 8'd3, 8'd1, 8'd2};

    initial begin
        int bh, bn, dh, dn, bc, bb;
        logic [31:0] exp_l[$];

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_vld", vld_h, 0);
        check("rst_busy", busy_h, 0);
        check("rst_done", done_h, 0);
        check("rst_ovr", ovr_h, 0);
        check("rst_cnt", cnt_h, 0);
        check("rst_addr", rd_addr_h, 0);

        // frame 1: all channels, rdy held high
        bh = q_h.size(); bn = q_n.size(); dh = done_ch; dn = done_cn;
        pulse_start(4'b1111, LENS1);
        wait_done("f1", dh, dn);
        check_seq("f1_h", 1'b1, bh, exp1_h);
        check_seq("f1_n", 1'b0, bn, exp1_n);
        check("f1_done_once", done_ch - dh, 1);
        check("f1_cnt_h", cnt_h, 10);
        check("f1_cnt_n", cnt_n, 6);

        // frame 2: sparse mask, no header
        bh = q_h.size(); bn = q_n.size(); dh = done_ch; dn = done_cn; bb = bad_chn;
        pulse_start(4'b0101, {8'd3, 8'd3, 8'd3, 8'd3});
        wait_done("f2", dh, dn);
        check_seq("f2_n", 1'b0, bn, exp2_n);
        check("f2_skip_chn", bad_chn - bb, 0);
        check("f2_cnt_n", cnt_n, 6);
        check("f2_cnt_h", cnt_h, 8);

        // frame 3: random backpressure
        bh = q_h.size(); bn = q_n.size(); dh = done_ch; dn = done_cn;
        rnd_rdy = 1'b1;
        pulse_start(4'b1111, LENS1);
        wait_done("f3", dh, dn);
        rnd_rdy = 1'b0;
        check_seq("f3_h", 1'b1, bh, exp1_h);
        check_seq("f3_n", 1'b0, bn, exp1_n);
        check("f3_stable", stab_err, 0);
        check("f3_cnt_h", cnt_h, 10);

        // frame 4: restart and input changes mid-frame
        bh = q_h.size(); dh = done_ch; dn = done_cn;
        pulse_start(4'b1111, LENS1);
        repeat (4) @(posedge clk);
        #1;
        check("f4_ovr_pre", ovr_h, 0);
        pulse_start(4'b0000, {8'd7, 8'd7, 8'd7, 8'd7});
        check("f4_ovr_set", ovr_h, 1);
        check("f4_busy", busy_h, 1);
        wait_done("f4", dh, dn);
        check_seq("f4_h", 1'b1, bh, exp1_h);
        check("f4_cnt_h", cnt_h, 10);
        check("f4_ovr_hold", ovr_h, 1);

        // frame 5: empty mask (mask/lens left at the mid-frame values)
        bh = q_h.size(); dh = done_ch; dn = done_cn; bc = busy_cyc;
        pulse_start(4'b0000, {8'd7, 8'd7, 8'd7, 8'd7});
        check("f5_ovr_clr", ovr_h, 0);
        wait_done("f5", dh, dn);
        check("f5_busy_cyc", busy_cyc - bc, 5);
        check("f5_words", q_h.size() - bh, 0);
        check("f5_cnt_h", cnt_h, 0);
        check("f5_done_once", done_ch - dh, 1);

        // reset while a data word is presented
        pulse_start(4'b1111, LENS1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (vld_h && data_h == 32'hD0000000) begin seen = 1'b1; break; end
            end
            check("rst_mid_seen", seen, 1);
        end
        rst = 1'b1;
        #1;
        check("rstm_vld", vld_h, 0);
        check("rstm_busy", busy_h, 0);
        check("rstm_done", done_h, 0);
        @(posedge clk); #1 rst = 1'b0;
        bh = q_h.size(); bn = q_n.size(); dh = done_ch; dn = done_cn;
        pulse_start(4'b1111, LENS1);
        wait_done("f6", dh, dn);
        check_seq("f6_h", 1'b1, bh, exp1_h);
        check("f6_cnt_h", cnt_h, 10);

        // max length on ch0, then ch1 starts back at address 0
        bh = q_h.size(); bn = q_n.size(); dh = done_ch; dn = done_cn;
        pulse_start(4'b0011, {8'd0, 8'd0, 8'd2, 8'd255});
        wait_done("f7", dh, dn);
        exp_l.delete();
        for (int a = 0; a < 255; a++) exp_l.push_back(32'hD0000000 | 32'(a));
        exp_l.push_back(32'hD0000100);
        exp_l.push_back(32'hD0000101);
        check_seq("f7_n", 1'b0, bn, exp_l);
        check("f7_cnt_n", cnt_n, 257);
        check("f7_cnt_h", cnt_h, 259);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
